mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Two-master, one-slave arbiter that shares the single simulated memory port between the core's instruction bus (ibus) and data bus (dbus). It sits between `riscv_ic` and the memory model, and serialises accesses with at most one transaction outstanding. It routes each response back only to the master that owns the transaction. Default policy is fixed dbus priority; round-robin is a compile-time option.

## Interface
Parameters:
- ADDR_W, 32, address width of all buses
- DATA_W, 32, data width of all buses

Ports. One clock; reset is asynchronous and active-low.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ibus_req_i  in  1  instruction fetch request
- ibus_addr_i  in  ADDR_W  fetch address
- ibus_gnt_o  out  1  fetch request accepted this cycle
- ibus_rvalid_o  out  1  fetch data valid
- ibus_rdata_o  out  DATA_W  fetch data
- dbus_req_i  in  1  data access request
- dbus_we_i  in  1  1 = store
- dbus_addr_i  in  ADDR_W  data address
- dbus_wdata_i  in  DATA_W  store data
- dbus_sel_i  in  4  byte enables
- dbus_gnt_o  out  1  data request accepted this cycle
- dbus_rvalid_o  out  1  load data valid, or store acknowledge
- dbus_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  request to memory
- mem_we_o  out  1  store
- mem_addr_o  out  ADDR_W  address
- mem_wdata_o  out  DATA_W  store data
- mem_sel_o  out  4  byte enables
- mem_gnt_i  in  1  memory accepts request
- mem_rvalid_i  in  1  response valid; asserted for loads and stores
- mem_rdata_i  in  DATA_W  response data
- err_o  out  1  sticky protocol error

## Operation
- FSM states: IDLE, WAIT_I, WAIT_D. Owner is implied by the state.
- IDLE
  - Select a winner among the asserted requests.
  - Drive mem_* combinationally from the winner's fields. For an ibus winner: we=0, sel=4'hF, wdata=0.
  - Drive the winner's gnt_o = mem_gnt_i. The loser's gnt_o = 0.
  - If mem_gnt_i=1: go to WAIT_I or WAIT_D.
  - With no request: mem_req_o=0 and all mem_* fields are 0.
- WAIT_x
  - mem_req_o=0; both gnt_o=0.
  - On mem_rvalid_i=1: pulse x_rvalid_o=1 with x_rdata_o=mem_rdata_i, combinational pass-through. Return to IDLE next cycle.
- rdata_o of the non-owner, or with no response, is 0.
- Fixed policy: dbus wins whenever dbus_req_i=1.
- A master must hold req and its fields stable until gnt. Deasserting req before gnt is legal and simply withdraws the request.
- Unexpected mem_rvalid_i while in IDLE: ignored, no rvalid_o pulse, err_o set.
- err_o clears only on reset.
- mem_gnt_i while mem_req_o=0: ignored.

## Timing
- Reset values: state=IDLE, err_o=0, last_owner=IBUS. All outputs 0.
- Request path adds zero cycles; grant occurs in the same cycle as mem_gnt_i.
- Response path adds zero cycles.
- Minimum spacing between grants is 2 cycles: grant cycle, then at least one WAIT cycle that includes the rvalid cycle.
- Memory answering with rvalid in the cycle after gnt gives back-to-back issue every 2 cycles.
- Simultaneous ibus_req_i and dbus_req_i are resolved by the policy in the Configuration section.
- Reset asserted mid-transaction: immediate return to IDLE and the pending response is dropped. A late mem_rvalid_i after reset release sets err_o.

## Configuration
- ARB_ROUND_ROBIN_EN
  - Defined: last_owner is updated on every grant. On a collision the master that did not own the previous grant wins. Neither master can be starved.
  - Undefined: fixed dbus priority. The last_owner register is not built.

## Structure
- `defines.v` holds:
  - State encodings: ARB_IDLE, ARB_WAIT_I, ARB_WAIT_D.
  - Owner encodings: OWNER_IBUS, OWNER_DBUS.
  - Bus-width macros, reusing `InstAddrBus` and `MemBus`.
- One sub-module, arb_pick2: a combinational 2-way picker.
  - Inputs: req[1:0] and last_owner.
  - Output: one-hot winner.
  - Its policy is selected by ARB_ROUND_ROBIN_EN.
- The FSM and routing live in mem_bus_arbiter.

## Test plan
- Reset: hold rst_n=0 with both reqs high -> all outputs 0. First cycle after release grants dbus, under both configurations.
- Single fetch: ibus_req_i at addr 0x8000_0000, mem_gnt_i same cycle, mem_rvalid_i next cycle with 0x0000_0413 -> ibus_gnt_o in cycle 0, ibus_rvalid_o/rdata 0x0000_0413 in cycle 1. dbus outputs stay 0.
- Store: dbus we=1, addr 0x8000_0100, wdata 0xDEAD_BEEF, sel 4'b0011 -> mem_* mirror these exactly. dbus_rvalid_o pulses on mem_rvalid_i.
- Collision, 4 transactions with both reqs held:
  - Fixed: D, D, D, D.
  - ARB_ROUND_ROBIN_EN: D, I, D, I.
- Memory stall: mem_gnt_i low for 3 cycles, then high -> mem_req_o held with stable fields for the 3 cycles and no gnt_o. Single grant on cycle 4.
- Errors:
  - Spurious mem_rvalid_i in IDLE -> err_o=1, no rvalid_o.
  - Reset pulse during WAIT_D -> IDLE, err_o=0. A later stray rvalid sets err_o.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory arbiter.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of the default fixed dbus priority.
package mem_bus_arbiter_pkg;

  // Default widths, inherited from the core's InstAddrBus / MemBus.
  localparam int unsigned INST_ADDR_BUS_W = 32;
  localparam int unsigned MEM_BUS_W       = 32;
  localparam int unsigned SEL_W           = 4;

  // Bit positions of each master in the picker request/grant vectors.
  localparam int unsigned REQ_IBUS = 0;
  localparam int unsigned REQ_DBUS = 1;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_WAIT_I = 2'd1,
    ARB_WAIT_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_IBUS = 1'b0,
    OWNER_DBUS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_bus_arbiter_pick2.sv
// arb_pick2: combinational two-way picker producing a one-hot winner.
// Build option: ARB_ROUND_ROBIN_EN. When it is defined, a collision goes to the
// master that did not own the previous grant. Otherwise dbus always wins.
module arb_pick2
  import mem_bus_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_e     last_owner_i,
`endif
  output logic [1:0] gnt_o
);

  // Pick at most one requester according to the configured policy.
  always_comb begin
    gnt_o = '0;
`ifdef ARB_ROUND_ROBIN_EN
    if (req_i[REQ_IBUS] && req_i[REQ_DBUS]) begin
      if (last_owner_i == OWNER_DBUS) begin
        gnt_o[REQ_IBUS] = 1'b1;
      end else begin
        gnt_o[REQ_DBUS] = 1'b1;
      end
    end else begin
      gnt_o = req_i;
    end
`else
    if (req_i[REQ_DBUS]) begin
      gnt_o[REQ_DBUS] = 1'b1;
    end else begin
      gnt_o[REQ_IBUS] = req_i[REQ_IBUS];
    end
`endif
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one memory port between the instruction bus and
// the data bus, with at most one transaction outstanding. Responses are
// routed only to the master that owns the transaction.
// Build option: ARB_ROUND_ROBIN_EN (round-robin). The default is fixed dbus priority.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = INST_ADDR_BUS_W,
  parameter int unsigned DATA_W = MEM_BUS_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ibus_req_i,
  input  logic [ADDR_W-1:0] ibus_addr_i,
  output logic              ibus_gnt_o,
  output logic              ibus_rvalid_o,
  output logic [DATA_W-1:0] ibus_rdata_o,
  input  logic              dbus_req_i,
  input  logic              dbus_we_i,
  input  logic [ADDR_W-1:0] dbus_addr_i,
  input  logic [DATA_W-1:0] dbus_wdata_i,
  input  logic [SEL_W-1:0]  dbus_sel_i,
  output logic              dbus_gnt_o,
  output logic              dbus_rvalid_o,
  output logic [DATA_W-1:0] dbus_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [SEL_W-1:0]  mem_sel_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              err_o
);

  arb_state_e state_q, state_d;
  logic       err_q, err_d;
  logic [1:0] pick_gnt;
  logic       grant_fire;

`ifdef ARB_ROUND_ROBIN_EN
  owner_e last_owner_q, last_owner_d;
`endif

  arb_pick2 u_pick (
    .req_i        ({dbus_req_i, ibus_req_i}),
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner_i (last_owner_q),
`endif
    .gnt_o        (pick_gnt)
  );

  // A grant happens only from IDLE, when memory accepts the winner's request.
  assign grant_fire = (state_q == ARB_IDLE) && (|pick_gnt) && mem_gnt_i;

  // Next state, request routing and response routing.
  // The whole decode is gated by rst_n. Otherwise requests held during
  // reset would leak through the IDLE combinational paths.
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    ibus_gnt_o    = 1'b0;
    ibus_rvalid_o = 1'b0;
    ibus_rdata_o  = '0;
    dbus_gnt_o    = 1'b0;
    dbus_rvalid_o = 1'b0;
    dbus_rdata_o  = '0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = '0;
    mem_sel_o     = '0;
    if (rst_n) begin
      unique case (state_q)
        ARB_IDLE: begin
          if (mem_rvalid_i) begin
            err_d = 1'b1;
          end
          if (pick_gnt[REQ_DBUS]) begin
            mem_req_o   = 1'b1;
            mem_we_o    = dbus_we_i;
            mem_addr_o  = dbus_addr_i;
            mem_wdata_o = dbus_wdata_i;
            mem_sel_o   = dbus_sel_i;
            dbus_gnt_o  = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d = ARB_WAIT_D;
            end
          end else if (pick_gnt[REQ_IBUS]) begin
            mem_req_o  = 1'b1;
            mem_addr_o = ibus_addr_i;
            mem_sel_o  = '1;
            ibus_gnt_o = mem_gnt_i;
            if (mem_gnt_i) begin
              state_d = ARB_WAIT_I;
            end
          end
        end
        ARB_WAIT_I: begin
          if (mem_rvalid_i) begin
            ibus_rvalid_o = 1'b1;
            ibus_rdata_o  = mem_rdata_i;
            state_d       = ARB_IDLE;
          end
        end
        ARB_WAIT_D: begin
          if (mem_rvalid_i) begin
            dbus_rvalid_o = 1'b1;
            dbus_rdata_o  = mem_rdata_i;
            state_d       = ARB_IDLE;
          end
        end
        default: begin
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

  assign err_o = err_q;

  // State and sticky error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Remember which master owned the most recent grant.
  always_comb begin
    last_owner_d = last_owner_q;
    if (grant_fire) begin
      last_owner_d = pick_gnt[REQ_DBUS] ? OWNER_DBUS : OWNER_IBUS;
    end
  end

  // Last-owner register for the round-robin policy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= OWNER_IBUS;
    end else begin
      last_owner_q <= last_owner_d;
    end
  end
`else
  logic unused_grant_fire;
  assign unused_grant_fire = grant_fire;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed steps followed by a random phase,
// all checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ibus_req_i, dbus_req_i, dbus_we_i;
  logic [31:0] ibus_addr_i, dbus_addr_i, dbus_wdata_i;
  logic [3:0]  dbus_sel_i;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        ibus_gnt_o, ibus_rvalid_o, dbus_gnt_o, dbus_rvalid_o;
  logic [31:0] ibus_rdata_o, dbus_rdata_o;
  logic        mem_req_o, mem_we_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_sel_o;

  int errors = 0;
  int checks = 0;

  // Reference model: one optional outstanding transaction and its owner.
  bit m_busy, m_own_d, m_err, m_last_d;

  // Output values seen at the most recent check point.
  logic        s_ig, s_dg, s_iv, s_dv, s_req, s_we, s_err;
  logic [31:0] s_ir, s_dr, s_addr, s_wdata;
  logic [3:0]  s_sel;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_req_i(ibus_req_i), .ibus_addr_i(ibus_addr_i), .ibus_gnt_o(ibus_gnt_o),
    .ibus_rvalid_o(ibus_rvalid_o), .ibus_rdata_o(ibus_rdata_o),
    .dbus_req_i(dbus_req_i), .dbus_we_i(dbus_we_i), .dbus_addr_i(dbus_addr_i),
    .dbus_wdata_i(dbus_wdata_i), .dbus_sel_i(dbus_sel_i), .dbus_gnt_o(dbus_gnt_o),
    .dbus_rvalid_o(dbus_rvalid_o), .dbus_rdata_o(dbus_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_sel_o(mem_sel_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: compare every output at the falling edge, then advance the model
  // at the rising edge. Inputs change 1 time unit after the rising edge.
  task automatic cyc(input string tag);
    logic        eig, edg, eiv, edv, ereq, ewe, eerr, win_i, win_d;
    logic [31:0] eir, edr, ea, ew;
    logic [3:0]  es;
    @(negedge clk);
    {eig, edg, eiv, edv, ereq, ewe} = '0;
    {eir, edr, ea, ew} = '0;
    es = '0;
    win_d = dbus_req_i && (!ibus_req_i || !RR || !m_last_d);
    win_i = ibus_req_i && !win_d;
    if (rst_n) begin
      if (!m_busy) begin
        if (win_d) begin
          ereq = 1'b1; ewe = dbus_we_i; ea = dbus_addr_i; ew = dbus_wdata_i;
          es = dbus_sel_i; edg = mem_gnt_i;
        end else if (win_i) begin
          ereq = 1'b1; ea = ibus_addr_i; es = 4'hF; eig = mem_gnt_i;
        end
      end else if (mem_rvalid_i) begin
        if (m_own_d) begin edv = 1'b1; edr = mem_rdata_i; end
        else begin eiv = 1'b1; eir = mem_rdata_i; end
      end
    end
    eerr = rst_n ? m_err : 1'b0;
    s_ig = ibus_gnt_o; s_dg = dbus_gnt_o; s_iv = ibus_rvalid_o; s_dv = dbus_rvalid_o;
    s_ir = ibus_rdata_o; s_dr = dbus_rdata_o; s_req = mem_req_o; s_we = mem_we_o;
    s_addr = mem_addr_o; s_wdata = mem_wdata_o; s_sel = mem_sel_o; s_err = err_o;
    check(tag,
      {err_o, mem_req_o, mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
       ibus_gnt_o, ibus_rvalid_o, ibus_rdata_o, dbus_gnt_o, dbus_rvalid_o, dbus_rdata_o},
      {eerr, ereq, ewe, es, ea, ew, eig, eiv, eir, edg, edv, edr});
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_err = 1'b0; m_last_d = 1'b0;
    end else if (!m_busy) begin
      if (mem_rvalid_i) m_err = 1'b1;
      if ((win_i || win_d) && mem_gnt_i) begin
        m_busy = 1'b1; m_own_d = win_d; m_last_d = win_d;
      end
    end else if (mem_rvalid_i) begin
      m_busy = 1'b0;
    end
    #1;
  endtask

  logic [1:0] exp_col [4];

  initial begin
    if (RR) begin
      exp_col[0] = 2'b10; exp_col[1] = 2'b01; exp_col[2] = 2'b10; exp_col[3] = 2'b01;
    end else begin
      exp_col[0] = 2'b10; exp_col[1] = 2'b10; exp_col[2] = 2'b10; exp_col[3] = 2'b10;
    end
    m_busy = 0; m_own_d = 0; m_err = 0; m_last_d = 0;
    rst_n = 1'b0;
    ibus_req_i = 1'b1; dbus_req_i = 1'b1; dbus_we_i = 1'b0;
    ibus_addr_i = 32'h0000_1000; dbus_addr_i = 32'h0000_2000;
    dbus_wdata_i = 32'h1234_5678; dbus_sel_i = 4'hF;
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hCAFE_F00D;

    // Reset with both requests high: every output quiet.
    repeat (3) cyc("reset_hold");
    check("reset_outputs",
      {mem_req_o, ibus_gnt_o, dbus_gnt_o, ibus_rvalid_o, dbus_rvalid_o, err_o, mem_addr_o}, '0);

    // First cycle after release grants dbus.
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc("first_grant");
    check("first_grant_dbus", {s_dg, s_ig}, 2'b10);
    ibus_req_i = 0; dbus_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    cyc("first_resp");
    mem_rvalid_i = 0;

    // Single fetch.
    ibus_req_i = 1; ibus_addr_i = 32'h8000_0000; mem_gnt_i = 1;
    cyc("fetch_req");
    check("fetch_gnt", {s_ig, s_req, s_addr, s_sel, s_we}, {1'b1, 1'b1, 32'h8000_0000, 4'hF, 1'b0});
    ibus_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0413;
    cyc("fetch_resp");
    check("fetch_rdata", {s_iv, s_ir}, {1'b1, 32'h0000_0413});
    check("fetch_dbus_quiet", {s_dg, s_dv, s_dr}, '0);
    mem_rvalid_i = 0;

    // Store.
    dbus_req_i = 1; dbus_we_i = 1; dbus_addr_i = 32'h8000_0100;
    dbus_wdata_i = 32'hDEAD_BEEF; dbus_sel_i = 4'b0011; mem_gnt_i = 1;
    cyc("store_req");
    check("store_fields", {s_dg, s_we, s_addr, s_wdata, s_sel},
          {1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011});
    dbus_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0;
    cyc("store_ack");
    check("store_rvalid", {s_dv, s_iv}, 2'b10);
    mem_rvalid_i = 0;

    // Fresh reset, then four collisions with both requests held.
    rst_n = 0; cyc("col_reset"); rst_n = 1;
    ibus_req_i = 1; dbus_req_i = 1; dbus_we_i = 0;
    for (int k = 0; k < 4; k++) begin
      mem_gnt_i = 1; mem_rvalid_i = 0;
      cyc("col_grant");
      check($sformatf("collision_%0d", k), {s_dg, s_ig}, exp_col[k]);
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h100 + 32'(k);
      cyc("col_resp");
    end
    ibus_req_i = 0; dbus_req_i = 0; mem_rvalid_i = 0;

    // Memory stall: request held three cycles without a grant.
    dbus_req_i = 1; dbus_addr_i = 32'h0000_0040; dbus_wdata_i = 32'h5555_AAAA; dbus_sel_i = 4'hC;
    mem_gnt_i = 0;
    for (int k = 0; k < 3; k++) begin
      cyc("stall");
      check($sformatf("stall_%0d", k), {s_req, s_addr, s_sel, s_dg, s_ig},
            {1'b1, 32'h0000_0040, 4'hC, 1'b0, 1'b0});
    end
    mem_gnt_i = 1;
    cyc("stall_grant");
    check("stall_grant_once", {s_dg, s_ig}, 2'b10);
    dbus_req_i = 0; mem_gnt_i = 0; mem_rvalid_i = 1;
    cyc("stall_resp");
    mem_rvalid_i = 0;

    // Spurious response in IDLE.
    mem_rvalid_i = 1;
    cyc("spurious");
    check("spurious_no_rvalid", {s_iv, s_dv}, 2'b00);
    mem_rvalid_i = 0;
    cyc("spurious_after");
    check("spurious_err", s_err, 1'b1);

    // Reset during WAIT_D, then a stray response.
    rst_n = 0; cyc("wd_reset0"); rst_n = 1;
    dbus_req_i = 1; dbus_we_i = 0; mem_gnt_i = 1;
    cyc("wd_grant");
    dbus_req_i = 0; mem_gnt_i = 0;
    rst_n = 0;
    cyc("wd_reset");
    check("wd_reset_quiet", {s_req, s_err, s_dv}, 3'b000);
    rst_n = 1;
    cyc("wd_idle");
    check("wd_err_clear", s_err, 1'b0);
    mem_rvalid_i = 1;
    cyc("wd_stray");
    check("wd_stray_no_rvalid", {s_iv, s_dv}, 2'b00);
    mem_rvalid_i = 0;
    cyc("wd_after");
    check("wd_stray_err", s_err, 1'b1);

    // Random phase.
    rst_n = 0; cyc("rand_reset"); rst_n = 1;
    for (int n = 0; n < 500; n++) begin
      ibus_req_i   = 1'($urandom_range(0, 1));
      dbus_req_i   = 1'($urandom_range(0, 1));
      dbus_we_i    = 1'($urandom_range(0, 1));
      ibus_addr_i  = $urandom();
      dbus_addr_i  = $urandom();
      dbus_wdata_i = $urandom();
      dbus_sel_i   = 4'($urandom_range(0, 15));
      mem_gnt_i    = 1'($urandom_range(0, 1));
      mem_rvalid_i = ($urandom_range(0, 99) < (m_busy ? 60 : 3));
      mem_rdata_i  = $urandom();
      rst_n        = ($urandom_range(0, 99) != 0);
      cyc("random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
